// File: rtl/mc_hs_rx_pkg.sv
// ---------------------------------------------------------------------------
// mc_hs_rx_pkg
// Shared types, default parameter values and width helpers for the
// multi-channel 4-phase handshake receiver.
//   ch_state_t : per-channel handshake state (IDLE / ACK)
//   clog2      : ceiling log2 usable in constant expressions
//   ch_width   : channel-id width, never below 1 bit
// ---------------------------------------------------------------------------
package mc_hs_rx_pkg;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_TIMEOUT     = 1023;

  // ST_ACK is encoded as 1 so that the ack output is the state flop itself.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } ch_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  function automatic int ch_width(input int num_ch);
    return (num_ch <= 1) ? 1 : clog2(num_ch);
  endfunction

endpackage

// File: rtl/mc_hs_rx_channel.sv
// ---------------------------------------------------------------------------
// mc_hs_rx_channel
// One receive channel: synchronises the asynchronous 4-phase request, runs
// the IDLE/ACK handshake FSM, captures the sender-held word into a one-entry
// hold register and, when HS_TIMEOUT_EN is defined, flags a sender that
// leaves req high for TIMEOUT cycles after ack rose.
// Optional feature macro: HS_TIMEOUT_EN
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   req         asynchronous request from the sender
//   data        sender data word, stable while req is high
//   ack         acknowledge back to the sender (state flop)
//   hold_data   captured word
//   hold_valid  hold register occupied
//   drain       arbiter takes the held word this edge
//   timeout     sticky timeout flag (0 when the feature is compiled out)
// ---------------------------------------------------------------------------
module mc_hs_rx_channel
  import mc_hs_rx_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  ack,
  output logic [DATA_WIDTH-1:0] hold_data,
  output logic                  hold_valid,
  input  logic                  drain,
  output logic                  timeout
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  ch_state_t              state;
  ch_state_t              state_next;
  logic                   capture;

  // Only req crosses domains through flops; data is guaranteed stable by the
  // protocol once req_s is seen high, so it is sampled directly on capture.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, which is what makes a shift chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], req};
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic. A full hold register withholds ack, which stalls the
  // sender until the arbiter has drained the previous word.
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (req_s && !hold_valid) state_next = ST_ACK;
      ST_ACK:  if (!req_s)               state_next = ST_IDLE;
      default:                           state_next = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ack     = (state == ST_ACK);
    capture = (state == ST_IDLE) && req_s && !hold_valid;
  end

  // Capture needs hold_valid low and drain needs it high, so the two never
  // coincide on one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          hold_valid <= 1'b0;
    else if (capture) hold_valid <= 1'b1;
    else if (drain)   hold_valid <= 1'b0;
  end

  // NOTE: the data word has no reset; it is only ever observed behind
  // hold_valid, which is reset, so resetting it would buy nothing.
  always_ff @(posedge clk) begin
    if (capture) hold_data <= data;
  end

`ifdef HS_TIMEOUT_EN
  localparam int TW = clog2(TIMEOUT + 1);

  logic [TW-1:0] to_cnt;

  // Counts edges spent in ACK after the ack rise and saturates at TIMEOUT;
  // the flag is set on the edge the count reaches TIMEOUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt  <= '0;
      timeout <= 1'b0;
    end else if (capture) begin
      to_cnt <= '0;
    end else if (state == ST_ACK && to_cnt != TW'(TIMEOUT)) begin
      to_cnt <= to_cnt + TW'(1);
      if (to_cnt == TW'(TIMEOUT - 1)) timeout <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: rtl/multi_channel_handshake_receiver.sv
// ---------------------------------------------------------------------------
// multi_channel_handshake_receiver
// Receives NUM_CH independent asynchronous 4-phase req/ack transfers and
// merges the captured words round-robin onto one valid/ready stream tagged
// with the source channel.
// Optional feature macro: HS_TIMEOUT_EN (per-channel sticky timeout flags)
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   req_i       per-channel request (asynchronous)
//   data_i      channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   ack_o       per-channel acknowledge
//   m_data      output word
//   m_chan      source channel of m_data
//   m_valid     output word valid
//   m_ready     consumer ready
//   timeout_o   sticky per-channel timeout flags
// ---------------------------------------------------------------------------
module multi_channel_handshake_receiver
  import mc_hs_rx_pkg::*;
#(
  parameter int  DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int  NUM_CH      = DEF_NUM_CH,
  parameter int  SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int  TIMEOUT     = DEF_TIMEOUT,
  localparam int CH_W        = ch_width(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            req_i,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_i,
  output logic [NUM_CH-1:0]            ack_o,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic [CH_W-1:0]              m_chan,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [NUM_CH-1:0]            timeout_o
);

  logic [NUM_CH-1:0]     hold_valid;
  logic [NUM_CH-1:0]     drain;
  logic [DATA_WIDTH-1:0] hold_data [NUM_CH];

  logic [CH_W-1:0]       rr_ptr;
  logic [CH_W-1:0]       rr_next;
  logic [CH_W-1:0]       winner;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  found;
  logic                  load;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    mc_hs_rx_channel #(
      .DATA_WIDTH  (DATA_WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .TIMEOUT     (TIMEOUT)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .req        (req_i[c]),
      .data       (data_i[c*DATA_WIDTH +: DATA_WIDTH]),
      .ack        (ack_o[c]),
      .hold_data  (hold_data[c]),
      .hold_valid (hold_valid[c]),
      .drain      (drain[c]),
      .timeout    (timeout_o[c])
    );
  end

  // Round-robin search: first occupied hold register at or after rr_ptr,
  // wrapping past NUM_CH-1. The extra sum bit lets the wrap work for channel
  // counts that are not a power of two.
  always_comb begin
    logic [CH_W:0]   sum;
    logic [CH_W-1:0] idx;
    found    = 1'b0;
    winner   = '0;
    win_data = '0;
    sum      = '0;
    idx      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sum = {1'b0, rr_ptr} + (CH_W + 1)'(i);
      if (sum >= (CH_W + 1)'(NUM_CH)) sum = sum - (CH_W + 1)'(NUM_CH);
      idx = sum[CH_W-1:0];
      if (!found && hold_valid[idx]) begin
        found    = 1'b1;
        winner   = idx;
        win_data = hold_data[idx];
      end
    end
  end

  // The output register refills whenever it is empty or being accepted,
  // which gives one word per cycle under continuous m_ready.
  always_comb begin
    load    = !m_valid || m_ready;
    rr_next = (winner == CH_W'(NUM_CH - 1)) ? '0 : winner + CH_W'(1);
    drain   = '0;
    if (load && found) drain[winner] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_chan  <= '0;
      rr_ptr  <= '0;
    end else if (load) begin
      if (found) begin
        m_valid <= 1'b1;
        m_data  <= win_data;
        m_chan  <= winner;
        rr_ptr  <= rr_next;
      end else begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_handshake_receiver.sv
// ---------------------------------------------------------------------------
// tb_multi_channel_handshake_receiver
// Directed self-checking bench for multi_channel_handshake_receiver with
// DATA_WIDTH=32, NUM_CH=4, SYNC_STAGES=2, TIMEOUT=15. Inputs change and
// outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_multi_channel_handshake_receiver;

  localparam int DW = 32;
  localparam int NC = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [NC-1:0]   req_i;
  logic [NC*DW-1:0] data_i;
  logic [NC-1:0]   ack_o;
  logic [DW-1:0]   m_data;
  logic [1:0]      m_chan;
  logic            m_valid;
  logic            m_ready;
  logic [NC-1:0]   timeout_o;

  int vectors     = 0;
  int miscompares = 0;

  multi_channel_handshake_receiver #(
    .DATA_WIDTH  (DW),
    .NUM_CH      (NC),
    .SYNC_STAGES (2),
    .TIMEOUT     (15)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .data_i    (data_i),
    .ack_o     (ack_o),
    .m_data    (m_data),
    .m_chan    (m_chan),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .timeout_o (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Bounded wait for ack_o[ch] to reach val; the final check reports expiry.
  task automatic wait_ack(input int ch, input logic val, input string tag);
    int n;
    n = 0;
    while (ack_o[ch] !== val && n < 20) begin
      cycle();
      n++;
    end
    check(tag, ack_o[ch], val);
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req_i = '0;
    repeat (2) cycle();
    rst = 1'b0;
    cycle();
  endtask

  task automatic set_data(input int ch, input logic [DW-1:0] val);
    data_i[ch*DW +: DW] = val;
  endtask

  initial begin
    logic stable;
    logic emitted;

    rst     = 1'b1;
    req_i   = '0;
    data_i  = '0;
    m_ready = 1'b1;
    #1;
    check("rst_ack",     ack_o,     4'h0);
    check("rst_valid",   m_valid,   1'b0);
    check("rst_data",    m_data,    32'h0);
    check("rst_chan",    m_chan,    2'd0);
    check("rst_timeout", timeout_o, 4'h0);
    @(negedge clk);
    do_reset();

    // Single ch2 transfer: ack at edge 2, word after edge 3.
    set_data(2, 32'hA5A5_0001);
    req_i[2] = 1'b1;
    cycle(); check("t1_ack_e0", ack_o[2], 1'b0);
    cycle(); check("t1_ack_e1", ack_o[2], 1'b0);
    cycle(); check("t1_ack_e2", ack_o[2], 1'b1);
             check("t1_valid_e2", m_valid, 1'b0);
    cycle(); check("t1_valid_e3", m_valid, 1'b1);
             check("t1_data", m_data, 32'hA5A5_0001);
             check("t1_chan", m_chan, 2'd2);
    req_i[2] = 1'b0;
    cycle(); check("t1_accepted", m_valid, 1'b0);
             check("t1_ack_hold0", ack_o[2], 1'b1);
    cycle(); check("t1_ack_hold1", ack_o[2], 1'b1);
    cycle(); check("t1_ack_fall", ack_o[2], 1'b0);

    // rr pointer is now 3: ch3 and ch0 pending together -> ch3 then ch0.
    set_data(3, 32'h0000_0033);
    set_data(0, 32'h0000_0030);
    req_i = 4'b1001;
    wait_ack(3, 1'b1, "t4_ack3_rise");
    check("t4_ack_both", ack_o, 4'b1001);
    cycle(); check("t4_first_chan", m_chan, 2'd3);
             check("t4_first_data", m_data, 32'h33);
    cycle(); check("t4_second_chan", m_chan, 2'd0);
             check("t4_second_data", m_data, 32'h30);
    cycle(); check("t4_drained", m_valid, 1'b0);
    req_i = '0;
    wait_ack(3, 1'b0, "t4_ack3_fall");
    check("t4_ack_all_low", ack_o, 4'h0);

    // All four channels together after reset: ch0..ch3 on consecutive cycles.
    do_reset();
    for (int c = 0; c < NC; c++) set_data(c, 32'h10 + c);
    req_i = '1;
    wait_ack(0, 1'b1, "t2_ack_rise");
    check("t2_ack_all", ack_o, 4'hF);
    for (int c = 0; c < NC; c++) begin
      cycle();
      check($sformatf("t2_valid%0d", c), m_valid, 1'b1);
      check($sformatf("t2_chan%0d", c),  m_chan, c);
      check($sformatf("t2_data%0d", c),  m_data, 32'h10 + c);
    end
    cycle(); check("t2_empty", m_valid, 1'b0);
    req_i = '0;
    wait_ack(0, 1'b0, "t2_ack_fall");

    // rr pointer should have wrapped to 0: ch1 beats ch3.
    set_data(1, 32'h11);
    set_data(3, 32'h31);
    req_i = 4'b1010;
    wait_ack(1, 1'b1, "rr0_ack");
    cycle(); check("rr0_first", m_chan, 2'd1);
    cycle(); check("rr0_second", m_chan, 2'd3);
             check("rr0_second_data", m_data, 32'h31);
    req_i = '0;
    wait_ack(1, 1'b0, "rr0_ack_fall");
    cycle();

    // Backpressure: word A in output, word B in hold, word C withheld.
    m_ready = 1'b0;
    set_data(1, 32'hAAAA_0001);
    req_i[1] = 1'b1;
    wait_ack(1, 1'b1, "t3_a_ack");
    cycle(); check("t3_a_valid", m_valid, 1'b1);
             check("t3_a_data", m_data, 32'hAAAA_0001);
    req_i[1] = 1'b0;
    wait_ack(1, 1'b0, "t3_a_ack_fall");
    set_data(1, 32'hBBBB_0002);
    req_i[1] = 1'b1;
    wait_ack(1, 1'b1, "t3_b_ack");
    req_i[1] = 1'b0;
    wait_ack(1, 1'b0, "t3_b_ack_fall");
    set_data(1, 32'hCCCC_0003);
    req_i[1] = 1'b1;
    stable = 1'b1;
    repeat (20) begin
      cycle();
      if (ack_o[1] !== 1'b0 || m_valid !== 1'b1 || m_data !== 32'hAAAA_0001) stable = 1'b0;
    end
    check("t3_stall_hold", stable, 1'b1);
    check("t3_ack_withheld", ack_o[1], 1'b0);
    m_ready = 1'b1;
    cycle(); check("t3_b_out", m_data, 32'hBBBB_0002);
             check("t3_b_valid", m_valid, 1'b1);
    cycle(); check("t3_c_ack", ack_o[1], 1'b1);
             check("t3_gap", m_valid, 1'b0);
    cycle(); check("t3_c_out", m_data, 32'hCCCC_0003);
             check("t3_c_valid", m_valid, 1'b1);
    req_i[1] = 1'b0;
    cycle(); check("t3_c_accepted", m_valid, 1'b0);
    wait_ack(1, 1'b0, "t3_c_ack_fall");

    // Reset mid-transfer with a word held in the output register.
    m_ready = 1'b0;
    set_data(0, 32'hDEAD_0005);
    req_i[0] = 1'b1;
    wait_ack(0, 1'b1, "t5_ack");
    cycle(); check("t5_valid", m_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_ack", ack_o, 4'h0);
    check("t5_rst_valid", m_valid, 1'b0);
    check("t5_rst_data", m_data, 32'h0);
    req_i = '0;
    @(negedge clk);
    cycle();
    rst     = 1'b0;
    m_ready = 1'b1;
    emitted = 1'b0;
    repeat (8) begin
      cycle();
      if (m_valid !== 1'b0) emitted = 1'b1;
    end
    check("t5_no_word", emitted, 1'b0);
    check("t5_ack_low", ack_o, 4'h0);

`ifdef HS_TIMEOUT_EN
    // ch1 req held high: flag after 15 cycles in ACK, sticky after req falls.
    set_data(1, 32'h7777_0001);
    req_i[1] = 1'b1;
    wait_ack(1, 1'b1, "to_ack");
    repeat (14) cycle();
    check("to_before", timeout_o[1], 1'b0);
    cycle();
    check("to_set", timeout_o[1], 1'b1);
    check("to_others", timeout_o & 4'b1101, 4'h0);
    req_i[1] = 1'b0;
    wait_ack(1, 1'b0, "to_ack_fall");
    repeat (3) cycle();
    check("to_sticky", timeout_o[1], 1'b1);
`else
    check("timeout_off", timeout_o, 4'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
